// File: rtl/alu_issue_queue_if.sv
// Enqueue, wakeup and ALU-issue signals of alu_issue_queue, bundled as one interface.
// The producer/consumer side uses the master modport; the queue uses the slave modport.
interface alu_issue_queue_if;
  logic        enq_valid_i;
  logic        enq_ready_o;
  logic [3:0]  enq_opc_i;
  logic [4:0]  enq_rob_id_i;
  logic [5:0]  enq_dest_i;
  logic [5:0]  enq_src1_tag_i;
  logic        enq_src1_rdy_i;
  logic [31:0] enq_src1_data_i;
  logic [5:0]  enq_src2_tag_i;
  logic        enq_src2_rdy_i;
  logic [31:0] enq_src2_data_i;
  logic        wb_valid_i;
  logic [5:0]  wb_dest_i;
  logic [31:0] wb_data_i;
  logic        alu_valid_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic [3:0]  alu_opc_o;
  logic [4:0]  alu_rob_id_o;
  logic [5:0]  alu_dest_o;

  modport master (
    output enq_valid_i, enq_opc_i, enq_rob_id_i, enq_dest_i,
    output enq_src1_tag_i, enq_src1_rdy_i, enq_src1_data_i,
    output enq_src2_tag_i, enq_src2_rdy_i, enq_src2_data_i,
    output wb_valid_i, wb_dest_i, wb_data_i,
    input  enq_ready_o,
    input  alu_valid_o, alu_a_o, alu_b_o, alu_opc_o, alu_rob_id_o, alu_dest_o
  );

  modport slave (
    input  enq_valid_i, enq_opc_i, enq_rob_id_i, enq_dest_i,
    input  enq_src1_tag_i, enq_src1_rdy_i, enq_src1_data_i,
    input  enq_src2_tag_i, enq_src2_rdy_i, enq_src2_data_i,
    input  wb_valid_i, wb_dest_i, wb_data_i,
    output enq_ready_o,
    output alu_valid_o, alu_a_o, alu_b_o, alu_opc_o, alu_rob_id_o, alu_dest_o
  );
endinterface

// File: rtl/alu_issue_queue.sv
// ALU issue queue: holds up to ENTRIES ops, captures operands from the writeback
// bus, and issues the oldest op whose two sources are ready, one per cycle.
// Entries are kept compacted in age order (slot 0 = oldest); an issue shifts the
// younger slots down and a new op is appended behind the survivors.
// Optional: define ALU_IQ_PERF_EN to build the issue / full-stall perf counters.
module alu_issue_queue #(
  parameter int ENTRIES = 4
) (
  input  logic                 cpu_clock_i,
  input  logic                 cpu_reset_i,
  input  logic                 flush_i,
  alu_issue_queue_if.slave     bus,
  output logic [31:0]          perf_issue_cnt_o,
  output logic [31:0]          perf_full_cnt_o
);
  localparam int IW = $clog2(ENTRIES);
  localparam int CW = $clog2(ENTRIES + 1);

  typedef struct packed {
    logic [3:0]  opc;
    logic [4:0]  rob_id;
    logic [5:0]  dest;
    logic [5:0]  tag1;
    logic        rdy1;
    logic [31:0] data1;
    logic [5:0]  tag2;
    logic        rdy2;
    logic [31:0] data2;
  } entry_t;

  entry_t          ent_reg   [ENTRIES];
  entry_t          ent_woken [ENTRIES];
  entry_t          ent_next  [ENTRIES];
  entry_t          enq_entry;
  logic [CW-1:0]   count_reg, count_next, count_after;
  logic [ENTRIES-1:0] eligible;
  logic            issue;
  logic [IW-1:0]   sel;
  logic            wake;
  logic            enq_fire;

  logic            alu_valid_reg;
  logic [31:0]     alu_a_reg, alu_b_reg;
  logic [3:0]      alu_opc_reg;
  logic [4:0]      alu_rob_id_reg;
  logic [5:0]      alu_dest_reg;

  // Physical register 0 is never a wakeup target.
  assign wake     = bus.wb_valid_i && (bus.wb_dest_i != 6'd0);
  assign bus.enq_ready_o = (count_reg < CW'(ENTRIES));
  assign enq_fire = bus.enq_valid_i && bus.enq_ready_o && !flush_i;

  // Eligibility uses start-of-cycle ready bits, so a wakeup issues one cycle later.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_elig
      assign eligible[gi] = (CW'(gi) < count_reg) && ent_reg[gi].rdy1 && ent_reg[gi].rdy2;
    end
  endgenerate

  // Capture writeback data into waiting sources of queued entries.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ent_woken[i] = ent_reg[i];
      if (wake && !ent_reg[i].rdy1 && ent_reg[i].tag1 == bus.wb_dest_i) begin
        ent_woken[i].rdy1  = 1'b1;
        ent_woken[i].data1 = bus.wb_data_i;
      end
      if (wake && !ent_reg[i].rdy2 && ent_reg[i].tag2 == bus.wb_dest_i) begin
        ent_woken[i].rdy2  = 1'b1;
        ent_woken[i].data2 = bus.wb_data_i;
      end
    end
  end

  // Build the incoming entry, bypassing a same-cycle wakeup into unready sources.
  always_comb begin
    enq_entry.opc    = bus.enq_opc_i;
    enq_entry.rob_id = bus.enq_rob_id_i;
    enq_entry.dest   = bus.enq_dest_i;
    enq_entry.tag1   = bus.enq_src1_tag_i;
    enq_entry.rdy1   = bus.enq_src1_rdy_i;
    enq_entry.data1  = bus.enq_src1_data_i;
    enq_entry.tag2   = bus.enq_src2_tag_i;
    enq_entry.rdy2   = bus.enq_src2_rdy_i;
    enq_entry.data2  = bus.enq_src2_data_i;
    if (wake && !bus.enq_src1_rdy_i && bus.enq_src1_tag_i == bus.wb_dest_i) begin
      enq_entry.rdy1  = 1'b1;
      enq_entry.data1 = bus.wb_data_i;
    end
    if (wake && !bus.enq_src2_rdy_i && bus.enq_src2_tag_i == bus.wb_dest_i) begin
      enq_entry.rdy2  = 1'b1;
      enq_entry.data2 = bus.wb_data_i;
    end
  end

  // Pick the lowest (oldest) eligible slot.
  always_comb begin
    issue = 1'b0;
    sel   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        issue = 1'b1;
        sel   = IW'(i);
      end
    end
  end

  // Compact out the issued slot, then append any enqueue behind the survivors.
  always_comb begin
    count_after = count_reg - CW'(issue);
    for (int i = 0; i < ENTRIES; i++) begin
      ent_next[i] = ent_woken[i];
    end
    for (int i = 0; i < ENTRIES - 1; i++) begin
      if (issue && IW'(i) >= sel) begin
        ent_next[i] = ent_woken[i + 1];
      end
    end
    if (enq_fire) begin
      ent_next[count_after[IW-1:0]] = enq_entry;
    end
    count_next = flush_i ? '0 : (count_after + CW'(enq_fire));
  end

  // Queue state and ALU issue registers; flush cancels the issue in flight.
  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      count_reg      <= '0;
      alu_valid_reg  <= 1'b0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_opc_reg    <= '0;
      alu_rob_id_reg <= '0;
      alu_dest_reg   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ent_reg[i] <= '0;
      end
    end else begin
      count_reg     <= count_next;
      alu_valid_reg <= issue && !flush_i;
      for (int i = 0; i < ENTRIES; i++) begin
        ent_reg[i] <= ent_next[i];
      end
      if (issue && !flush_i) begin
        alu_a_reg      <= ent_reg[sel].data1;
        alu_b_reg      <= ent_reg[sel].data2;
        alu_opc_reg    <= ent_reg[sel].opc;
        alu_rob_id_reg <= ent_reg[sel].rob_id;
        alu_dest_reg   <= ent_reg[sel].dest;
      end
    end
  end

  assign bus.alu_valid_o  = alu_valid_reg;
  assign bus.alu_a_o      = alu_a_reg;
  assign bus.alu_b_o      = alu_b_reg;
  assign bus.alu_opc_o    = alu_opc_reg;
  assign bus.alu_rob_id_o = alu_rob_id_reg;
  assign bus.alu_dest_o   = alu_dest_reg;

`ifdef ALU_IQ_PERF_EN
  logic [31:0] perf_issue_reg, perf_full_reg;

  // Count issued ops and cycles where a request met a full queue; flush leaves them alone.
  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      perf_issue_reg <= '0;
      perf_full_reg  <= '0;
    end else begin
      if (issue && !flush_i) begin
        perf_issue_reg <= perf_issue_reg + 32'd1;
      end
      if (bus.enq_valid_i && !bus.enq_ready_o) begin
        perf_full_reg <= perf_full_reg + 32'd1;
      end
    end
  end

  assign perf_issue_cnt_o = perf_issue_reg;
  assign perf_full_cnt_o  = perf_full_reg;
`else
  assign perf_issue_cnt_o = 32'd0;
  assign perf_full_cnt_o  = 32'd0;
`endif
endmodule

// File: tb/tb_alu_issue_queue.sv
// Testbench for alu_issue_queue: directed scenarios plus random traffic, checked
// by a scoreboard fed from a queue-based reference model of the issue queue.
module tb_alu_issue_queue;
  localparam int ENTRIES = 4;

  typedef struct packed {
    logic [3:0]  opc;
    logic [4:0]  rob;
    logic [5:0]  dest;
    logic [5:0]  t1;
    logic        r1;
    logic [31:0] d1;
    logic [5:0]  t2;
    logic        r2;
    logic [31:0] d2;
  } op_t;

  typedef struct {
    int          ecyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  opc;
    logic [4:0]  rob;
    logic [5:0]  dest;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] perf_issue, perf_full;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  op_t  m_q[$];
  exp_t exp_q[$];
  int   m_issue = 0;
  int   m_full = 0;
  logic [31:0] last_a, last_b;
  logic [3:0]  last_opc;
  logic [4:0]  last_rob;
  logic [5:0]  last_dest;

  alu_issue_queue_if bus();

  alu_issue_queue #(.ENTRIES(ENTRIES)) dut (
    .cpu_clock_i      (clk),
    .cpu_reset_i      (rst),
    .flush_i          (flush),
    .bus              (bus),
    .perf_issue_cnt_o (perf_issue),
    .perf_full_cnt_o  (perf_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic drive(input bit ev, input op_t op, input bit wbv, input logic [5:0] wbd,
                       input logic [31:0] wbdat, input bit fl);
    bus.enq_valid_i     = ev;
    bus.enq_opc_i       = op.opc;
    bus.enq_rob_id_i    = op.rob;
    bus.enq_dest_i      = op.dest;
    bus.enq_src1_tag_i  = op.t1;
    bus.enq_src1_rdy_i  = op.r1;
    bus.enq_src1_data_i = op.d1;
    bus.enq_src2_tag_i  = op.t2;
    bus.enq_src2_rdy_i  = op.r2;
    bus.enq_src2_data_i = op.d2;
    bus.wb_valid_i      = wbv;
    bus.wb_dest_i       = wbd;
    bus.wb_data_i       = wbdat;
    flush               = fl;
  endtask

  // Reference model: the queue is an age-ordered list; apply one clock edge of behaviour.
  task automatic model_step(input bit ev, input op_t op, input bit wbv, input logic [5:0] wbd,
                            input logic [31:0] wbdat, input bit fl);
    bit   has_room;
    int   pick;
    op_t  o;
    exp_t e;
    has_room = (m_q.size() < ENTRIES);
    if (ev && !has_room) m_full++;
    if (fl) begin
      m_q.delete();
      return;
    end
    pick = -1;
    for (int i = 0; i < m_q.size(); i++)
      if (pick < 0 && m_q[i].r1 && m_q[i].r2) pick = i;
    if (pick >= 0) begin
      e.ecyc = cyc + 1;
      e.a    = m_q[pick].d1;
      e.b    = m_q[pick].d2;
      e.opc  = m_q[pick].opc;
      e.rob  = m_q[pick].rob;
      e.dest = m_q[pick].dest;
      exp_q.push_back(e);
      m_issue++;
      m_q.delete(pick);
    end
    if (wbv && wbd != 6'd0) begin
      for (int i = 0; i < m_q.size(); i++) begin
        if (!m_q[i].r1 && m_q[i].t1 == wbd) begin m_q[i].r1 = 1'b1; m_q[i].d1 = wbdat; end
        if (!m_q[i].r2 && m_q[i].t2 == wbd) begin m_q[i].r2 = 1'b1; m_q[i].d2 = wbdat; end
      end
    end
    if (ev && has_room) begin
      o = op;
      if (wbv && wbd != 6'd0 && !o.r1 && o.t1 == wbd) begin o.r1 = 1'b1; o.d1 = wbdat; end
      if (wbv && wbd != 6'd0 && !o.r2 && o.t2 == wbd) begin o.r2 = 1'b1; o.d2 = wbdat; end
      m_q.push_back(o);
    end
  endtask

  // One cycle of stimulus: drive, check ready and perf state, advance the model.
  task automatic step(input bit ev, input op_t op, input bit wbv, input logic [5:0] wbd,
                      input logic [31:0] wbdat, input bit fl);
    @(posedge clk);
    #1;
    drive(ev, op, wbv, wbd, wbdat, fl);
    chk("enq_ready", {31'b0, bus.enq_ready_o}, {31'b0, (m_q.size() < ENTRIES)});
`ifdef ALU_IQ_PERF_EN
    chk("perf_issue", perf_issue, m_issue);
    chk("perf_full", perf_full, m_full);
`else
    chk("perf_issue", perf_issue, 32'd0);
    chk("perf_full", perf_full, 32'd0);
`endif
    model_step(ev, op, wbv, wbd, wbdat, fl);
  endtask

  task automatic idle(input int n);
    op_t z;
    z = '0;
    for (int i = 0; i < n; i++) step(1'b0, z, 1'b0, 6'd0, 32'd0, 1'b0);
  endtask

  function automatic op_t mk(input logic [3:0] opc, input logic [4:0] rob, input logic [5:0] dest,
                             input logic [5:0] t1, input logic r1, input logic [31:0] d1,
                             input logic [5:0] t2, input logic r2, input logic [31:0] d2);
    op_t o;
    o.opc = opc; o.rob = rob; o.dest = dest;
    o.t1 = t1; o.r1 = r1; o.d1 = d1;
    o.t2 = t2; o.r2 = r2; o.d2 = d2;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.opc  = 4'($urandom);
    o.rob  = 5'($urandom);
    o.dest = 6'($urandom);
    o.r1   = 1'($urandom_range(0, 1));
    o.t1   = o.r1 ? 6'($urandom_range(0, 7)) : 6'($urandom_range(1, 7));
    o.d1   = $urandom;
    o.r2   = 1'($urandom_range(0, 1));
    o.t2   = o.r2 ? 6'($urandom_range(0, 7)) : 6'($urandom_range(1, 7));
    o.d2   = $urandom;
    return o;
  endfunction

  // Monitor: pop and compare on each issue, check hold and missed issues otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      last_a = '0; last_b = '0; last_opc = '0; last_rob = '0; last_dest = '0;
    end else if (bus.alu_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {31'b0, bus.alu_valid_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        $display("issue cycle=%0d rob=%0d dest=%0d opc=%0h a=%h b=%h",
                 cyc, bus.alu_rob_id_o, bus.alu_dest_o, bus.alu_opc_o, bus.alu_a_o, bus.alu_b_o);
        chk("issue_cycle", cyc, e.ecyc);
        chk("alu_a", bus.alu_a_o, e.a);
        chk("alu_b", bus.alu_b_o, e.b);
        chk("alu_opc", {28'b0, bus.alu_opc_o}, {28'b0, e.opc});
        chk("alu_rob_id", {27'b0, bus.alu_rob_id_o}, {27'b0, e.rob});
        chk("alu_dest", {26'b0, bus.alu_dest_o}, {26'b0, e.dest});
      end
      last_a = bus.alu_a_o; last_b = bus.alu_b_o; last_opc = bus.alu_opc_o;
      last_rob = bus.alu_rob_id_o; last_dest = bus.alu_dest_o;
    end else begin
      chk("hold_a", bus.alu_a_o, last_a);
      chk("hold_b", bus.alu_b_o, last_b);
      chk("hold_opc", {28'b0, bus.alu_opc_o}, {28'b0, last_opc});
      chk("hold_rob", {27'b0, bus.alu_rob_id_o}, {27'b0, last_rob});
      chk("hold_dest", {26'b0, bus.alu_dest_o}, {26'b0, last_dest});
      if (exp_q.size() > 0 && exp_q[0].ecyc <= cyc) begin
        e = exp_q.pop_front();
        chk("missing_issue_cycle", cyc, e.ecyc);
      end
    end
  end

  initial begin
    op_t z, o;
    bit ev, wbv, fl;
    logic [5:0] wbd;
    z = '0;
    drive(1'b0, z, 1'b0, 6'd0, 32'd0, 1'b0);

    // Reset state
    #12;
    chk("rst_alu_valid", {31'b0, bus.alu_valid_o}, 32'd0);
    chk("rst_alu_a", bus.alu_a_o, 32'd0);
    chk("rst_alu_dest", {26'b0, bus.alu_dest_o}, 32'd0);
    chk("rst_perf_issue", perf_issue, 32'd0);
    chk("rst_perf_full", perf_full, 32'd0);
    @(posedge clk); #3 rst = 1'b0;
    idle(2);

    // Both sources ready: two-cycle latency
    step(1'b1, mk(4'd0, 5'd3, 6'd9, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7), 1'b0, 6'd0, 32'd0, 1'b0);
    idle(4);

    // Wakeup of src1 three cycles after enqueue
    step(1'b1, mk(4'd3, 5'd1, 6'd10, 6'd12, 1'b0, 32'd0, 6'd13, 1'b1, 32'h1234), 1'b0, 6'd0, 32'd0, 1'b0);
    idle(2);
    step(1'b0, z, 1'b1, 6'd12, 32'hDEADBEEF, 1'b0);
    idle(4);

    // Enqueue bypass from a same-cycle writeback
    step(1'b1, mk(4'd5, 5'd4, 6'd11, 6'd3, 1'b1, 32'h99, 6'd20, 1'b0, 32'd0), 1'b1, 6'd20, 32'h11, 1'b0);
    idle(4);

    // Fill with unready ops, stall a fifth, wake all at once, expect age order
    for (int i = 0; i < 4; i++)
      step(1'b1, mk(4'(i), 5'(i), 6'(20 + i), 6'd40, 1'b0, 32'd0, 6'd40, 1'b0, 32'd0), 1'b0, 6'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, mk(4'd9, 5'd9, 6'd29, 6'd1, 1'b1, 32'd1, 6'd1, 1'b1, 32'd2), 1'b0, 6'd0, 32'd0, 1'b0);
    step(1'b0, z, 1'b1, 6'd40, 32'hCAFE0040, 1'b0);
    idle(6);

    // Flush with a concurrent enqueue; wb to register 0 must not wake anything
    step(1'b1, mk(4'd1, 5'd10, 6'd1, 6'd50, 1'b0, 32'd0, 6'd2, 1'b1, 32'd2), 1'b0, 6'd0, 32'd0, 1'b0);
    step(1'b1, mk(4'd2, 5'd11, 6'd2, 6'd3, 1'b1, 32'd3, 6'd51, 1'b0, 32'd0), 1'b0, 6'd0, 32'd0, 1'b0);
    step(1'b1, mk(4'd3, 5'd12, 6'd3, 6'd0, 1'b0, 32'd0, 6'd4, 1'b1, 32'd4), 1'b0, 6'd0, 32'd0, 1'b0);
    step(1'b0, z, 1'b1, 6'd0, 32'hABCD, 1'b0);
    step(1'b1, mk(4'd4, 5'd13, 6'd4, 6'd5, 1'b1, 32'd5, 6'd6, 1'b1, 32'd6), 1'b0, 6'd0, 32'd0, 1'b1);
    step(1'b0, z, 1'b1, 6'd50, 32'h50, 1'b0);
    step(1'b0, z, 1'b1, 6'd51, 32'h51, 1'b0);
    step(1'b1, mk(4'd6, 5'd14, 6'd7, 6'd5, 1'b1, 32'h77, 6'd6, 1'b1, 32'h88), 1'b0, 6'd0, 32'd0, 1'b0);
    idle(4);

    // Asynchronous reset while an issue is on the ALU outputs
    step(1'b1, mk(4'd7, 5'd15, 6'd15, 6'd1, 1'b1, 32'h101, 6'd1, 1'b1, 32'h102), 1'b0, 6'd0, 32'd0, 1'b0);
    step(1'b1, mk(4'd8, 5'd16, 6'd16, 6'd1, 1'b1, 32'h201, 6'd1, 1'b1, 32'h202), 1'b0, 6'd0, 32'd0, 1'b0);
    step(1'b1, mk(4'd9, 5'd17, 6'd17, 6'd1, 1'b1, 32'h301, 6'd1, 1'b1, 32'h302), 1'b0, 6'd0, 32'd0, 1'b0);
    #1;
    chk("pre_reset_valid", {31'b0, bus.alu_valid_o}, 32'd1);
    rst = 1'b1;
    drive(1'b0, z, 1'b0, 6'd0, 32'd0, 1'b0);
    m_q.delete();
    m_issue = 0;
    m_full = 0;
    #1;
    chk("async_rst_valid", {31'b0, bus.alu_valid_o}, 32'd0);
    chk("async_rst_a", bus.alu_a_o, 32'd0);
    chk("async_rst_rob", {27'b0, bus.alu_rob_id_o}, 32'd0);
    chk("async_rst_perf_issue", perf_issue, 32'd0);
    @(posedge clk);
    @(posedge clk); #3 rst = 1'b0;
    idle(4);
    step(1'b1, mk(4'd2, 5'd18, 6'd18, 6'd1, 1'b1, 32'h401, 6'd1, 1'b1, 32'h402), 1'b0, 6'd0, 32'd0, 1'b0);
    idle(3);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      o   = rand_op();
      ev  = ($urandom_range(0, 9) < 6);
      wbv = 1'($urandom_range(0, 1));
      wbd = 6'($urandom_range(0, 7));
      fl  = ($urandom_range(0, 49) == 0);
      step(ev, o, wbv, wbd, $urandom, fl);
    end

    // Drain: wake every tag the random ops could be waiting on
    for (int k = 0; k < 16; k++)
      step(1'b0, z, 1'b1, 6'(1 + (k % 7)), $urandom, 1'b0);
    idle(6);
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
